// File: rtl/multdiv_issue.sv
// -----------------------------------------------------------------------------
// multdiv_issue
//
// Issue/collect controller sitting in front of the iterative Booth multiplier
// core. It latches a multiply request, holds the core in clear for one launch
// cycle, and then lets the core run. It captures the product and overflow flag
// when the core reports ready, or a timeout (result 0, exception 1) when the
// watchdog expires. The captured result is then presented with a one-cycle
// strobe.
//
// Optional feature (compile-time macro MULT_ZERO_BYPASS_EN):
//   When defined, a start whose sampled operands include a zero skips the
//   core entirely and completes in one cycle with result 0, exception 0.
//   When undefined, zero operands take the normal launch/run path.
//
// Parameters
//   WIDTH     operand / result width
//   MAX_WAIT  run cycles allowed before the watchdog fires (2..63)
//
// Ports
//   clk               rising-edge clock
//   clr               asynchronous active-low reset
//   ctrl_MULT         start strobe; operandA/operandB are sampled with it
//   operandA/B        multiplicand / multiplier from the pipeline
//   core_result       product from the core
//   core_exception    overflow flag from the core
//   core_ready        core done flag
//   core_multiplicand registered operandA, stable for the whole operation
//   core_multiplier   registered operandB, stable for the whole operation
//   core_clr          active-high clear to the core (low only while running)
//   busy              stall request to the pipeline (launch and run)
//   data_resultRDY    one-cycle completion strobe
//   data_result       captured product
//   data_exception    captured overflow or timeout
// -----------------------------------------------------------------------------
module multdiv_issue #(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 24
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic [WIDTH-1:0] core_result,
    input  logic             core_exception,
    input  logic             core_ready,
    output logic [WIDTH-1:0] core_multiplicand,
    output logic [WIDTH-1:0] core_multiplier,
    output logic             core_clr,
    output logic             busy,
    output logic             data_resultRDY,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Six bits cover the full MAX_WAIT range of 2..63.
    localparam int               CNT_W      = 6;
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               exc_q, exc_d;

`ifdef MULT_ZERO_BYPASS_EN
    logic               start_zero;
    assign start_zero = (operandA == '0) || (operandB == '0);
`endif

    // The counter holds the number of completed run cycles, so cnt_inc is the
    // index of the current run cycle; the watchdog fires in run cycle MAX_WAIT.
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        exc_d   = exc_q;

        if (ctrl_MULT) begin
            // A start is accepted in every state and takes priority over a
            // capture in the same cycle, so an aborted run leaves the
            // captured result untouched.
            opa_d = operandA;
            opb_d = operandB;
`ifdef MULT_ZERO_BYPASS_EN
            if (start_zero) begin
                state_d = DONE;
                res_d   = '0;
                exc_d   = 1'b0;
            end else begin
                state_d = LAUNCH;
            end
`else
            state_d = LAUNCH;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                LAUNCH: begin
                    // core_ready is still left over from the previous
                    // operation here, so it is not looked at.
                    state_d = RUN;
                    cnt_d   = '0;
                end
                RUN: begin
                    cnt_d = cnt_inc;
                    if (core_ready) begin
                        // Ready wins over a watchdog expiring in the same cycle.
                        res_d   = core_result;
                        exc_d   = core_exception;
                        state_d = DONE;
                    end else if (cnt_inc == WAIT_LIMIT) begin
                        res_d   = '0;
                        exc_d   = 1'b1;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
        end
    end

    // Every output is a register or a decode of the state register only.
    assign core_multiplicand = opa_q;
    assign core_multiplier   = opb_q;
    assign data_result       = res_q;
    assign data_exception    = exc_q;
    assign core_clr          = (state_q != RUN);
    assign busy              = (state_q == LAUNCH) || (state_q == RUN);
    assign data_resultRDY    = (state_q == DONE);

endmodule

// File: tb/tb_multdiv_issue.sv
// -----------------------------------------------------------------------------
// tb_multdiv_issue
//
// Self-checking bench for multdiv_issue (WIDTH=32, MAX_WAIT=24). A small core
// model computes the signed product and overflow flag. Expected completions
// are queued when a start is driven and are popped when the strobe appears.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_multdiv_issue;

    localparam int W    = 32;
    localparam int MAXW = 24;

    typedef struct {
        logic [W-1:0] res;
        logic         exc;
    } exp_t;

    logic         clk = 1'b0;
    logic         clr;
    logic         ctrl_MULT;
    logic [W-1:0] operandA, operandB, core_result;
    logic         core_exception, core_ready;
    logic [W-1:0] core_multiplicand, core_multiplier, data_result;
    logic         core_clr, busy, data_resultRDY, data_exception;

    int   checks = 0;
    int   fails  = 0;
    exp_t sb[$];

    multdiv_issue #(.WIDTH(W), .MAX_WAIT(MAXW)) dut (
        .clk              (clk),
        .clr              (clr),
        .ctrl_MULT        (ctrl_MULT),
        .operandA         (operandA),
        .operandB         (operandB),
        .core_result      (core_result),
        .core_exception   (core_exception),
        .core_ready       (core_ready),
        .core_multiplicand(core_multiplicand),
        .core_multiplier  (core_multiplier),
        .core_clr         (core_clr),
        .busy             (busy),
        .data_resultRDY   (data_resultRDY),
        .data_result      (data_result),
        .data_exception   (data_exception)
    );

    always #5 clk = ~clk;

    // Core model: {overflow, low WIDTH bits of the signed product}.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        logic   ovf;
        p   = longint'($signed(a)) * longint'($signed(b));
        ovf = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        return {ovf, p[W-1:0]};
    endfunction

    // Drives one operation and watches the DUT for 'budget' cycles after the
    // start edge. ready_k > 0 raises core_ready in that run cycle, 0 never.
    // A stale core_ready is presented during the launch cycle.
    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input int ready_k, input int budget,
                            output int lat, output int busy_cnt, output int clr_low,
                            output int strobes, output logic [W-1:0] res, output logic exc);
        logic [W:0] m;
        exp_t       e;
        m = model(a, b);
`ifdef MULT_ZERO_BYPASS_EN
        if (a == '0 || b == '0) begin
            e.res = '0; e.exc = 1'b0;
        end else
`endif
        if (ready_k == 0 || ready_k > MAXW) begin
            e.res = '0; e.exc = 1'b1;
        end else begin
            e.res = m[W-1:0]; e.exc = m[W];
        end
        @(negedge clk);
        ctrl_MULT = 1'b1; operandA = a; operandB = b; core_ready = 1'b0;
        sb.push_back(e);
        lat = 0; busy_cnt = 0; clr_low = 0; strobes = 0; res = '0; exc = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            ctrl_MULT = 1'b0;
            if (busy)      busy_cnt++;
            if (!core_clr) clr_low++;
            if (data_resultRDY) begin
                strobes++;
                if (lat == 0) begin
                    lat = i; res = data_result; exc = data_exception;
                end
            end
            if (i == 1) begin
                core_ready = 1'b1; core_result = 32'hDEADBEEF; core_exception = 1'b1;
            end else if (ready_k > 0 && i == ready_k + 1) begin
                core_ready = 1'b1; core_result = m[W-1:0]; core_exception = m[W];
            end else begin
                core_ready = 1'b0; core_result = 32'hDEADBEEF; core_exception = 1'b1;
            end
        end
        core_ready = 1'b0;
    endtask

    task automatic test_reset;
        clr = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({core_clr, busy, data_resultRDY, data_exception} !== 4'b1000) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 1000", {core_clr, busy, data_resultRDY, data_exception});
        end
        checks++;
        if ({data_result, core_multiplicand, core_multiplier} !== '0) begin
            fails++;
            $display("FAIL reset_data: got %h/%h/%h want 0", data_result, core_multiplicand, core_multiplier);
        end
        clr = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_exception;
        int lat, bc, cl, st; logic [W-1:0] r; logic e; exp_t x;
        drive_op(32'h40000000, 32'd4, 5, 12, lat, bc, cl, st, r, e);
        if (sb.size() == 0) begin x.res = 'x; x.exc = 1'bx; end else x = sb.pop_front();
        checks++;
        if (lat !== 7) begin fails++; $display("FAIL exc_latency: got %0d want 7", lat); end
        checks++;
        if (e !== x.exc || r !== x.res) begin
            fails++; $display("FAIL exc_value: got %h/%b want %h/%b", r, e, x.res, x.exc);
        end
        checks++;
        if (data_exception !== 1'b1 || data_result !== '0) begin
            fails++; $display("FAIL exc_hold: got %h/%b want 00000000/1", data_result, data_exception);
        end
        checks++;
        if (st !== 1) begin fails++; $display("FAIL exc_strobes: got %0d want 1", st); end
    endtask

    task automatic test_basic;
        int lat, bc, cl, st; logic [W-1:0] r; logic e; exp_t x;
        drive_op(32'd7, 32'hFFFFFFFD, 17, 24, lat, bc, cl, st, r, e);
        if (sb.size() == 0) begin x.res = 'x; x.exc = 1'bx; end else x = sb.pop_front();
        checks++;
        if (bc !== 18) begin fails++; $display("FAIL basic_busy: got %0d want 18", bc); end
        checks++;
        if (cl !== 17) begin fails++; $display("FAIL basic_clr_low: got %0d want 17", cl); end
        checks++;
        if (lat !== 19 || st !== 1) begin
            fails++; $display("FAIL basic_strobe: got lat %0d cnt %0d want lat 19 cnt 1", lat, st);
        end
        checks++;
        if (r !== x.res || e !== x.exc || r !== 32'hFFFFFFEB) begin
            fails++; $display("FAIL basic_value: got %h/%b want %h/%b", r, e, x.res, x.exc);
        end
        checks++;
        if (core_multiplicand !== 32'd7 || core_multiplier !== 32'hFFFFFFFD) begin
            fails++; $display("FAIL basic_operands: got %h/%h want 00000007/fffffffd", core_multiplicand, core_multiplier);
        end
    endtask

    task automatic test_timeout;
        int lat, bc, cl, st; logic [W-1:0] r; logic e; exp_t x;
        drive_op(32'h00012345, 32'd3, 0, 32, lat, bc, cl, st, r, e);
        if (sb.size() == 0) begin x.res = 'x; x.exc = 1'bx; end else x = sb.pop_front();
        checks++;
        if (lat !== MAXW + 2 || st !== 1) begin
            fails++; $display("FAIL timeout_strobe: got lat %0d cnt %0d want lat %0d cnt 1", lat, st, MAXW + 2);
        end
        checks++;
        if (r !== x.res || e !== x.exc) begin
            fails++; $display("FAIL timeout_value: got %h/%b want %h/%b", r, e, x.res, x.exc);
        end
        checks++;
        if (bc !== MAXW + 1) begin fails++; $display("FAIL timeout_busy: got %0d want %0d", bc, MAXW + 1); end
        // Ready in the very run cycle where the watchdog would fire.
        drive_op(32'hFFFFFFFB, 32'd6, MAXW, 32, lat, bc, cl, st, r, e);
        if (sb.size() == 0) begin x.res = 'x; x.exc = 1'bx; end else x = sb.pop_front();
        checks++;
        if (lat !== MAXW + 2 || r !== x.res || e !== x.exc || r !== 32'hFFFFFFE2) begin
            fails++; $display("FAIL ready_vs_timeout: got lat %0d %h/%b want lat %0d %h/%b", lat, r, e, MAXW + 2, x.res, x.exc);
        end
    endtask

    task automatic test_reset_mid_run;
        @(negedge clk);
        ctrl_MULT = 1'b1; operandA = 32'd11; operandB = 32'd13;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            ctrl_MULT = 1'b0;
        end
        checks++;
        if (busy !== 1'b1 || core_clr !== 1'b0) begin
            fails++; $display("FAIL midrun_state: got busy %b clr %b want 1/0", busy, core_clr);
        end
        #1 clr = 1'b0;
        @(negedge clk);
        checks++;
        if ({core_clr, busy, data_resultRDY, data_exception} !== 4'b1000 ||
            {data_result, core_multiplicand, core_multiplier} !== '0) begin
            fails++;
            $display("FAIL midrun_reset: got ctl %b data %h ops %h/%h want 1000 0 0/0",
                     {core_clr, busy, data_resultRDY, data_exception}, data_result, core_multiplicand, core_multiplier);
        end
        clr = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_restart;
        int   lat = 0, st = 0;
        logic [W-1:0] r = '0;
        logic e = 1'b0;
        exp_t x, ne;
        logic [W:0] m;
        @(negedge clk);
        ctrl_MULT = 1'b1; operandA = 32'd5; operandB = 32'd7;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            ctrl_MULT = 1'b0; core_ready = 1'b0;
            if (data_resultRDY) begin
                st++;
                if (lat == 0) begin lat = i; r = data_result; e = data_exception; end
            end
            if (i == 6) begin
                // Run cycle 5 of the first operation: restart with 2 x 3.
                ctrl_MULT = 1'b1; operandA = 32'd2; operandB = 32'd3;
                m = model(32'd2, 32'd3);
                ne.res = m[W-1:0]; ne.exc = m[W];
                sb.push_back(ne);
            end
            if (i == 7) begin
                checks++;
                if (busy !== 1'b1 || core_clr !== 1'b1 || core_multiplicand !== 32'd2 || core_multiplier !== 32'd3) begin
                    fails++; $display("FAIL restart_launch: got busy %b clr %b ops %h/%h want 1/1 2/3",
                                      busy, core_clr, core_multiplicand, core_multiplier);
                end
            end
            if (i == 10) begin
                core_ready = 1'b1; core_result = m[W-1:0]; core_exception = m[W];
            end
        end
        core_ready = 1'b0;
        if (sb.size() == 0) begin x.res = 'x; x.exc = 1'bx; end else x = sb.pop_front();
        checks++;
        if (st !== 1 || lat !== 11) begin
            fails++; $display("FAIL restart_strobe: got lat %0d cnt %0d want lat 11 cnt 1", lat, st);
        end
        checks++;
        if (r !== x.res || e !== x.exc || r !== 32'd6) begin
            fails++; $display("FAIL restart_value: got %h/%b want %h/%b", r, e, x.res, x.exc);
        end
    endtask

    task automatic test_zero;
        int lat, bc, cl, st; logic [W-1:0] r; logic e; exp_t x;
        drive_op(32'd0, 32'd9, 3, 10, lat, bc, cl, st, r, e);
        if (sb.size() == 0) begin x.res = 'x; x.exc = 1'bx; end else x = sb.pop_front();
        checks++;
        if (r !== x.res || e !== x.exc || st !== 1) begin
            fails++; $display("FAIL zero_value: got %h/%b cnt %0d want %h/%b cnt 1", r, e, st, x.res, x.exc);
        end
`ifdef MULT_ZERO_BYPASS_EN
        checks++;
        if (lat !== 1 || bc !== 0 || cl !== 0) begin
            fails++; $display("FAIL zero_bypass: got lat %0d busy %0d clrlow %0d want 1/0/0", lat, bc, cl);
        end
`else
        checks++;
        if (lat !== 5 || bc !== 4 || cl !== 3) begin
            fails++; $display("FAIL zero_normal: got lat %0d busy %0d clrlow %0d want 5/4/3", lat, bc, cl);
        end
`endif
    endtask

    initial begin
        clr = 1'b0; ctrl_MULT = 1'b0;
        operandA = '0; operandB = '0;
        core_result = '0; core_exception = 1'b0; core_ready = 1'b0;
        test_reset;
        test_exception;
        test_basic;
        test_timeout;
        test_reset_mid_run;
        test_restart;
        test_zero;
        checks++;
        if (sb.size() !== 0) begin
            fails++; $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/multdiv_issue.md
# multdiv_issue

Issue/collect controller that sits directly upstream of the iterative Booth multiplier core in the execute stage. It accepts a multiply request from the pipeline and latches the operands into stable registers. It pulses the core's clear, waits for the core's ready, and captures the product and overflow flag. It then presents them back to the pipeline with a one-cycle result-ready strobe and a busy/stall signal, plus a watchdog timeout.

## Interface
- `WIDTH`, default 32: operand/result width.
- `MAX_WAIT`, default 24: maximum RUN cycles before timeout (range 2–63).
- `clk`  in  1  rising-edge clock.
- `clr`  in  1  asynchronous, active-low reset.
- `ctrl_MULT`  in  1  start strobe, sampled each rising edge.
- `operandA`  in  WIDTH  multiplicand, sampled with `ctrl_MULT`.
- `operandB`  in  WIDTH  multiplier, sampled with `ctrl_MULT`.
- `core_result`  in  WIDTH  product from core.
- `core_exception`  in  1  overflow flag from core.
- `core_ready`  in  1  core done flag.
- `core_multiplicand`  out  WIDTH  registered operandA.
- `core_multiplier`  out  WIDTH  registered operandB.
- `core_clr`  out  1  active-high clear to core.
- `busy`  out  1  stall request to pipeline.
- `data_resultRDY`  out  1  one-cycle completion strobe.
- `data_result`  out  WIDTH  captured product.
- `data_exception`  out  1  captured overflow or timeout.

## Operation
- FSM states: IDLE, LAUNCH, RUN, DONE; reset state is IDLE.
- IDLE: `core_clr`=1, `busy`=0. On `ctrl_MULT`=1, latch operands and go to LAUNCH.
- LAUNCH (exactly 1 cycle): `core_clr`=1, `busy`=1. `core_ready` is ignored (stale). Next state is RUN; the wait counter is cleared to 0.
- RUN: `core_clr`=0, `busy`=1. The wait counter increments each cycle.
  - If `core_ready`=1, capture `core_result` into `data_result` and `core_exception` into `data_exception`, then go to DONE.
  - Else if the counter reaches `MAX_WAIT`, capture `data_result`=0 and `data_exception`=1, then go to DONE.
- DONE (1 cycle): `data_resultRDY`=1, `busy`=0, `core_clr`=1. Next state is IDLE.
- Restart: `ctrl_MULT`=1 in any state, including LAUNCH, RUN and DONE, relatches the operands and goes to LAUNCH.
  - Restart in RUN aborts with no strobe, and the captured outputs are unchanged.
  - Restart in DONE still emits that DONE cycle's strobe.
- Captured result: `data_result`/`data_exception` are registers. They change only on capture and hold until the next capture.
- Core operands: `core_multiplicand`/`core_multiplier` change only on an accepted start, so they are stable for the whole operation.
- Simultaneous events: `core_ready` and counter==`MAX_WAIT` in the same cycle → the ready capture wins (no timeout).
- Reset mid-operation: immediate return to IDLE; all outputs take their reset values.

## Timing
- Reset values: `core_clr`=1; `busy`, `data_resultRDY`, `data_exception` = 0; `data_result`, `core_multiplicand`, `core_multiplier` = 0.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Latency: start sampled at edge E0 → LAUNCH in the cycle after E0 → RUN from E1.
  - If `core_ready` is first high in the k-th RUN cycle, `data_resultRDY` is high in the cycle following edge E(1+k).
  - That is k+2 cycles after E0.
- Timeout: `data_resultRDY` is high `MAX_WAIT`+2 cycles after the start.
- `busy` is high in LAUNCH and RUN only. The pipeline must hold its dependent instruction while `busy`=1 and consume the result on `data_resultRDY`.

## Configuration
- `MULT_ZERO_BYPASS_EN` defined: if either sampled operand is 0, the block skips LAUNCH/RUN.
  - The FSM goes IDLE→DONE directly with `data_result`=0 and `data_exception`=0.
  - Latency is 1 cycle; `busy` stays 0 and `core_clr` stays 1.
- Not defined: zero operands follow the normal LAUNCH/RUN path.

## Test plan
- Reset asserted mid-RUN → next cycle state IDLE, `core_clr`=1, `busy`=0, `data_result`=0, `data_exception`=0.
- A=7, B=−3, core model raises `core_ready` in RUN cycle 17 with result 0xFFFFFFEB, exception 0 → `busy` high for 18 cycles, then `data_resultRDY` pulses once with `data_result`=0xFFFFFFEB.
- A=0x40000000, B=4, model returns exception=1 → `data_exception`=1 with the strobe; the value holds after the strobe until the next capture.
- Core model never raises ready, `MAX_WAIT`=24 → strobe at cycle 26 with `data_result`=0, `data_exception`=1.
- New `ctrl_MULT` (A=2, B=3) at RUN cycle 5 of an earlier op → no strobe for the old op, fresh LAUNCH, then a single strobe with 6.
- With `MULT_ZERO_BYPASS_EN`, A=0, B=9 → strobe 1 cycle after the start, result 0, `busy` never high, `core_clr` never low.
